// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device over open-drain CLK/DAT pads.
// Optional build macro PS2_TX_CLK_FILTER_EN adds a FILTER_LEN-sample stability filter on CLK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PARITY    = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd7;

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES/TIMEOUT_CYCLES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          done_q, done_d, err_q, err_d;
  logic          ready_q, ready_d, busy_q, busy_d;
  logic          clk_lvl, clk_fall, timed;

  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_dat_in;
    dat_sync_d = dat_meta_q;
    clk_prev_d = clk_lvl;
  end

`ifdef PS2_TX_CLK_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          flt_q, flt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;

  // The filtered level follows CLK only after FILTER_LEN samples in a row disagree with it.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_sync_q != flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) flt_d = clk_sync_q;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      flt_q     <= flt_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  assign clk_lvl = flt_q;
`else
  assign clk_lvl = clk_sync_q;
`endif

  assign clk_fall = clk_prev_q & ~clk_lvl;
  assign timed    = (state_q >= ST_REQ);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bitcnt_d  = bitcnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (timed && to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          data_d    = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes low while CLK is still held, so it is present the moment CLK is released.
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) dat_oe_d = 1'b1;
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          to_cnt_d = '0;
          bitcnt_d = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ, ST_DATA: begin
        state_d = ST_DATA;
        if (clk_fall) begin
          dat_oe_d = ~data_q[bitcnt_q[2:0]];
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_fall) begin
          dat_oe_d = ~parity_q;
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_fall) begin
          dat_oe_d = 1'b0;
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          bitcnt_d = bitcnt_q + 1'b1;
          if (!dat_sync_q) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_lvl && dat_sync_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout overrides whatever the current state decided, including a same-cycle ACK.
    if (timed && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = ST_IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b1;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device that clocks frames,
// records the bits it samples and optionally ACKs; results are compared with a frame-level model.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 4000;
  localparam int FL   = 4;
  localparam int HALF = 100;

`ifdef PS2_TX_CLK_FILTER_EN
  localparam int GLITCH_STEP = 0;
`else
  localparam int GLITCH_STEP = 1;
`endif

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         delay;
    int         hold;
    bit         exp_par;
    bit         exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, start_cnt = 0, both_cnt = 0, long_cnt = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_coe = 1'b0;

  // Open-drain pads: low whenever either side pulls.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // Pulse bookkeeping: counts done/error pulses, overlaps, stretched pulses and transfer starts.
  always @(negedge clk) begin
    prev_done <= tx_done;
    prev_err  <= tx_error;
    prev_coe  <= ps2_clk_oe;
    if (tx_done)                      done_cnt  <= done_cnt + 1;
    if (tx_error)                     err_cnt   <= err_cnt + 1;
    if (tx_done && tx_error)          both_cnt  <= both_cnt + 1;
    if ((tx_done && prev_done) || (tx_error && prev_err)) long_cnt <= long_cnt + 1;
    if (ps2_clk_oe && !prev_coe)      start_cnt <= start_cnt + 1;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones;
    logic [10:0] f;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) ones++;
      f[1 + i] = d[i];
    end
    f[0]  = 1'b0;
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) checkOutput("ready_wait", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic start_request(input logic [7:0] data, input int hold, output int inh);
    wait_ready();
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    checkOutput("accept_busy", {31'd0, tx_busy}, 32'd1);
    if (hold <= 1) tx_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && inh < 200) begin
      inh++;
      if (inh >= hold) tx_valid = 1'b0;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic dev_pulse();
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Device clocks 11 periods, samples each bit on the rising edge and ACKs after the stop bit.
  task automatic device_frame(input bit ack, input int delay, output logic [10:0] bits);
    bits = '0;
    repeat (delay) @(negedge clk);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps2_dat_in;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input bit ack, input int delay, input int hold,
                               input logic [10:0] exp_frame, input bit exp_done, input string name);
    int d0, e0, s0, inh;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = start_cnt;
    start_request(data, hold, inh);
    checkOutput({name, "/inhibit_len"}, inh, INH);
    checkOutput({name, "/start_bit_drv"}, {31'd0, ps2_dat_oe}, 32'd1);
    device_frame(ack, delay, bits);
    repeat (20) @(negedge clk);
    checkOutput({name, "/frame"}, {21'd0, bits}, {21'd0, exp_frame});
    checkOutput({name, "/done_pulses"}, done_cnt - d0, {31'd0, exp_done});
    checkOutput({name, "/error_pulses"}, err_cnt - e0, {31'd0, !exp_done});
    checkOutput({name, "/starts"}, start_cnt - s0, 32'd1);
    checkOutput({name, "/oe_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput({name, "/ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int inh, n, d0, e0;
    logic [3:0] b0, b1;
    logic [7:0] rd;
    bit rack;

    vecs[0] = '{data: 8'hED, ack: 1'b1, delay: 20,  hold: 1,   exp_par: 1'b1, exp_done: 1'b1};
    vecs[1] = '{data: 8'hF4, ack: 1'b0, delay: 40,  hold: 1,   exp_par: 1'b0, exp_done: 1'b0};
    vecs[2] = '{data: 8'hFF, ack: 1'b1, delay: 30,  hold: 100, exp_par: 1'b1, exp_done: 1'b1};
    vecs[3] = '{data: 8'h01, ack: 1'b1, delay: 150, hold: 1,   exp_par: 1'b0, exp_done: 1'b1};
    vecs[4] = '{data: 8'h80, ack: 1'b0, delay: 25,  hold: 3,   exp_par: 1'b0, exp_done: 1'b0};

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset/oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput("reset/ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset/busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset/pulses", done_cnt + err_cnt, 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].ack, vecs[i].delay, vecs[i].hold,
                    {1'b1, vecs[i].exp_par, vecs[i].data, 1'b0}, vecs[i].exp_done,
                    $sformatf("vec%0d", i));
    end

    // Device never clocks: error must land exactly TO cycles after REQ entry.
    d0 = done_cnt;
    start_request(8'hF4, 1, inh);
    n = 0;
    while (!tx_error && n < TO + 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout/cycles", n, TO);
    checkOutput("timeout/oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput("timeout/ready", {31'd0, tx_ready}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("timeout/no_done", done_cnt - d0, 32'd0);

    // Reset after the 4th data bit: lines released on the next edge, no pulses.
    rd = 8'hA5;
    d0 = done_cnt;
    e0 = err_cnt;
    start_request(rd, 1, inh);
    repeat (20) @(negedge clk);
    repeat (4) dev_pulse();
    checkOutput("reset_mid/pre_dat", {31'd0, ps2_dat_oe}, {31'd0, !rd[3]});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_mid/oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    checkOutput("reset_mid/busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_mid/ready", {31'd0, tx_ready}, 32'd1);
    repeat (300) @(negedge clk);
    checkOutput("reset_mid/pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    applyStimulus(8'h00, 1'b1, 20, 1, model_frame(8'h00), 1'b1, "after_reset");

    // Short CLK glitch during DATA.
    start_request(8'h3C, 1, inh);
    repeat (20) @(negedge clk);
    repeat (3) dev_pulse();
    b0 = dut.bitcnt_q;
    checkOutput("glitch/bitcnt_before", {28'd0, b0}, 32'd3);
    dev_clk_low = 1'b1;
    repeat (2) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (30) @(negedge clk);
    b1 = dut.bitcnt_q;
    checkOutput("glitch/bitcnt_step", {28'd0, b1 - b0}, GLITCH_STEP);
    pulse_reset();
    repeat (5) @(negedge clk);

    // Reset and tx_valid in the same cycle: reset wins.
    @(negedge clk);
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    reset    = 1'b0;
    tx_valid = 1'b0;
    checkOutput("reset_wins/ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset_wins/clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    @(negedge clk);
    checkOutput("reset_wins/busy", {31'd0, tx_busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      applyStimulus(rd, rack, int'($urandom_range(15, 300)), int'($urandom_range(1, 30)),
                    model_frame(rd), rack, $sformatf("rand%0d", i));
    end

    checkOutput("pulse/overlap", both_cnt, 32'd0);
    checkOutput("pulse/width", long_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
